// File: rtl/btn_pkg.sv
// Shared definitions for the button press controller and its consumers.
package btn_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    IDLE      = 2'd1,
    PRESSED   = 2'd2,
    LONG_HELD = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_LONG_LIMIT = 50_000_000;
  localparam int unsigned DEF_NUM_AXES   = 3;

  // Axis encoding also used by the SPI read sequencer downstream of axis_sel.
  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  // Advance the axis index, wrapping at the last axis.
  function automatic logic [1:0] next_axis(input logic [1:0] cur, input int unsigned num_axes);
    return (cur == 2'(num_axes - 1)) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/button_press_ctrl.sv
// Turns a debounced button level into press / short / long events and keeps
// the display axis select and freeze flag.
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_LOW  | after reset; waits for the button to be seen released
// IDLE      | button released, ready for a new press
// PRESSED   | button held, hold counter running toward the long limit
// LONG_HELD | long press already fired; waiting for release, no repeat
module button_press_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned LONG_LIMIT = DEF_LONG_LIMIT,
  parameter int unsigned NUM_AXES   = DEF_NUM_AXES,
  parameter int unsigned CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [1:0] axis_sel,
  output logic       freeze
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_LIMIT - 1);

  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, short_nxt, long_nxt, freeze_nxt;
  logic [1:0]       axis_nxt;

  // State, counter and all outputs are registered; reset abandons any press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_LOW;
      cnt         <= '0;
      press_pulse <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      axis_sel    <= AXIS_X;
      freeze      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      press_pulse <= press_nxt;
      short_pulse <= short_nxt;
      long_pulse  <= long_nxt;
      axis_sel    <= axis_nxt;
      freeze      <= freeze_nxt;
    end
  end

  // Next-state, hold counter and event decode.
  // The counter starts at 0 on the press edge so that long_pulse lands exactly
  // LONG_LIMIT cycles after press_pulse, and a release on the last count still
  // counts as a short press.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    press_nxt  = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    axis_nxt   = axis_sel;
    freeze_nxt = freeze;
    unique case (state)
      WAIT_LOW: begin
        cnt_nxt = '0;
        if (!btn_level) state_nxt = IDLE;
      end
      IDLE: begin
        if (btn_level) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
          axis_nxt  = next_axis(axis_sel, NUM_AXES);
        end else if (cnt == CNT_LAST) begin
          state_nxt  = LONG_HELD;
          cnt_nxt    = '0;
          long_nxt   = 1'b1;
          freeze_nxt = ~freeze;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        cnt_nxt = '0;
        if (!btn_level) state_nxt = IDLE;
      end
      default: begin
        state_nxt = WAIT_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_press_ctrl.sv
// Scoreboard bench for button_press_ctrl with LONG_LIMIT=8, NUM_AXES=3.
module tb_button_press_ctrl;

  localparam int LIMIT = 8;
  localparam int AXES  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_level;
  logic       press_pulse, short_pulse, long_pulse, freeze;
  logic [1:0] axis_sel;

  button_press_ctrl #(
    .LONG_LIMIT(LIMIT),
    .NUM_AXES  (AXES),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse),
    .axis_sel   (axis_sel),
    .freeze     (freeze)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;    // 0 press, 1 short, 2 long
    int edge_n;  // clock edge after which the pulse must be visible
    int axis;
    int frz;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_axis = 0;
  int   exp_frz  = 0;
  bit   mon_en   = 0;
  logic prev_p = 0, prev_s = 0, prev_l = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (press_pulse || short_pulse || long_pulse) begin
        int   kind;
        exp_t e;
        check("onehot", int'(press_pulse) + int'(short_pulse) + int'(long_pulse), 1);
        check("width", int'((press_pulse & prev_p) | (short_pulse & prev_s) | (long_pulse & prev_l)), 0);
        kind = long_pulse ? 2 : (short_pulse ? 1 : 0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", kind, -1);
        end else begin
          e = sb.pop_front();
          check("kind", kind, e.kind);
          check("edge", edge_cnt, e.edge_n);
          check("axis", int'(axis_sel), e.axis);
          check("freeze", int'(freeze), e.frz);
        end
      end
      prev_p = press_pulse;
      prev_s = short_pulse;
      prev_l = long_pulse;
    end
  end

  // One press from IDLE: n_high samples high, then n_low samples low.
  task automatic do_press(input int n_high, input int n_low);
    int r;
    @(negedge clk);
    r = edge_cnt + 1;
    sb.push_back('{kind: 0, edge_n: r, axis: exp_axis, frz: exp_frz});
    if (n_high > LIMIT) begin
      exp_frz = 1 - exp_frz;
      sb.push_back('{kind: 2, edge_n: r + LIMIT, axis: exp_axis, frz: exp_frz});
    end else begin
      exp_axis = (exp_axis == AXES - 1) ? 0 : exp_axis + 1;
      sb.push_back('{kind: 1, edge_n: r + n_high, axis: exp_axis, frz: exp_frz});
    end
    btn_level = 1'b1;
    repeat (n_high - 1) @(negedge clk);
    @(negedge clk);
    btn_level = 1'b0;
    repeat (n_low - 1) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_press"}, int'(press_pulse), 0);
    check({tag, "_short"}, int'(short_pulse), 0);
    check({tag, "_long"}, int'(long_pulse), 0);
    check({tag, "_axis"}, int'(axis_sel), 0);
    check({tag, "_freeze"}, int'(freeze), 0);
  endtask

  initial begin
    rst       = 1'b1;
    btn_level = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1;
    check_quiet("reset");

    // 1: held through reset, no pulses until seen low
    repeat (20) @(negedge clk);
    btn_level = 1'b0;
    repeat (2) @(negedge clk);
    do_press(3, 3);
    check("axis_after_first", int'(axis_sel), 1);

    // 2: short presses walk axis 1->2->0->1
    for (int i = 0; i < 3; i++) do_press(3, 3);
    check("axis_after_wrap", int'(axis_sel), 1);
    check("freeze_after_shorts", int'(freeze), 0);

    // 3: long hold
    do_press(20, 3);
    check("freeze_after_long", int'(freeze), 1);
    check("axis_after_long", int'(axis_sel), 1);

    // 4: 7-cycle hold and release exactly on the limit cycle
    do_press(7, 3);
    check("axis_hold7", int'(axis_sel), 2);
    do_press(8, 3);
    check("axis_hold8", int'(axis_sel), 0);
    check("freeze_hold8", int'(freeze), 1);

    // single-cycle low between presses: short then press on consecutive edges
    do_press(3, 1);
    do_press(3, 3);
    check("axis_repress", int'(axis_sel), 2);

    // 5: reset on cycle 5 of a press with the button still held
    @(negedge clk);
    sb.push_back('{kind: 0, edge_n: edge_cnt + 1, axis: exp_axis, frz: exp_frz});
    btn_level = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("midrst");
    exp_axis = 0;
    exp_frz  = 0;
    repeat (6) @(negedge clk);
    btn_level = 1'b0;
    repeat (2) @(negedge clk);
    do_press(3, 3);
    check("axis_after_midrst", int'(axis_sel), 1);

    // 6: two long presses back to back
    do_press(12, 2);
    check("freeze_long1", int'(freeze), 1);
    do_press(12, 3);
    check("freeze_long2", int'(freeze), 0);
    check("axis_after_longs", int'(axis_sel), 1);

    repeat (10) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
